// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: shared types and helpers for the MiniMIPS run controller.
//   run_state_t  : controller state encoding (IDLE, RUN, STEP_WAIT, HALTED, TIMEOUT)
//   TRACE_IDX_W  : index width needed to address a trace buffer of a given depth
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    HALTED    = 3'd3,
    TIMEOUT   = 3'd4
  } run_state_t;

  // Depth is a power of two >= 2, so the index is never narrower than one bit.
  function automatic int TRACE_IDX_W(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mips_run_controller_if.sv
// mips_run_controller_if: run-control, datapath PC and trace debug signals.
//   master (bench / datapath side): drives start, step_mode, step_req, halt_pc,
//          pc_next, trace_idx; observes pc_new, running, done, timeout,
//          cycle_count, trace_pc, trace_valid.
//   slave  (controller side): the mirror image.
interface mips_run_controller_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16,
  parameter int IDX_W = 3
);

  logic             start;
  logic             step_mode;
  logic             step_req;
  logic [PC_W-1:0]  halt_pc;
  logic [PC_W-1:0]  pc_next;
  logic [PC_W-1:0]  pc_new;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [IDX_W-1:0] trace_idx;
  logic [PC_W-1:0]  trace_pc;
  logic             trace_valid;

  modport master (
    output start, step_mode, step_req, halt_pc, pc_next, trace_idx,
    input  pc_new, running, done, timeout, cycle_count, trace_pc, trace_valid
  );

  modport slave (
    input  start, step_mode, step_req, halt_pc, pc_next, trace_idx,
    output pc_new, running, done, timeout, cycle_count, trace_pc, trace_valid
  );

endinterface

// File: rtl/pc_trace_buf.sv
// pc_trace_buf: circular history of the most recent TRACE_DEPTH executed PCs.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write push_pc at the write pointer and advance it
//   clear     : forget all entries (pointer and fill count back to 0)
//   rd_idx    : 0 = newest entry, 1 = the one before, ...
//   rd_pc     : selected entry, 0 when rd_idx is beyond the filled entries
//   rd_valid  : rd_idx < number of filled entries
module pc_trace_buf
  import mips_dbg_pkg::*;
#(
  parameter int  PC_W        = 32,
  parameter int  TRACE_DEPTH = 8,
  localparam int IDX_W       = TRACE_IDX_W(TRACE_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             clear,
  input  logic [PC_W-1:0]  push_pc,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [PC_W-1:0]  rd_pc,
  output logic             rd_valid
);

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(TRACE_DEPTH);

  logic [PC_W-1:0]  trace_mem [TRACE_DEPTH];
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   fill_q, fill_d;
  logic [IDX_W-1:0] rd_addr;

  // The pointer wraps for free because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (clear) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (fill_q != FULL) fill_d = fill_q + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // NOTE: the storage array has no reset; entries beyond the fill count are
  // never exposed (rd_pc is forced to 0), so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (push && !clear) trace_mem[wr_ptr_q] <= push_pc;
  end

  assign rd_addr  = wr_ptr_q - IDX_W'(1) - rd_idx;
  assign rd_valid = ({1'b0, rd_idx} < fill_q);
  assign rd_pc    = rd_valid ? trace_mem[rd_addr] : '0;

endmodule

// File: rtl/mips_run_controller.sv
// mips_run_controller: PC sequencer and run monitor for MiniMIPS.
//   pc_clk : single clock, all state updates on the rising edge
//   reset  : asynchronous active-high reset, clears all state
//   bus    : slave side of mips_run_controller_if
//            inputs  start, step_mode, step_req, halt_pc, pc_next, trace_idx
//            outputs pc_new, running, done, timeout, cycle_count,
//                    trace_pc, trace_valid
// A run begins on start, advances the PC once per step (every cycle in free
// run, once per step_req in single-step), and ends sticky in HALTED when the
// PC reaches the halt address or in TIMEOUT after MAX_CYCLES steps.
module mips_run_controller
  import mips_dbg_pkg::*;
#(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              TRACE_DEPTH = 8,
  parameter int              CNT_W       = 16,
  parameter int              MAX_CYCLES  = 1000
) (
  input logic                  pc_clk,
  input logic                  reset,
  mips_run_controller_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

  run_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trace_push;
  logic             trace_clear;

  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    halt_d      = halt_q;
    cnt_d       = cnt_q;
    trace_push  = 1'b0;
    trace_clear = 1'b0;

    unique case (state_q)
      // start is honoured only when no run is in progress; finished runs
      // restart directly without passing through IDLE.
      IDLE, HALTED, TIMEOUT: begin
        if (bus.start) begin
          pc_d        = RESET_PC;
          halt_d      = bus.halt_pc;
          cnt_d       = '0;
          trace_clear = 1'b1;
          state_d     = bus.step_mode ? STEP_WAIT : RUN;
        end
      end

      RUN, STEP_WAIT: begin
        // Halt beats timeout when both hold on the same cycle.
        if (pc_q == halt_q) begin
          state_d = HALTED;
        end else if (cnt_q == MAX_CNT) begin
          state_d = TIMEOUT;
        end else begin
          if (state_q == RUN || bus.step_req) begin
            pc_d       = bus.pc_next;
            cnt_d      = cnt_q + CNT_W'(1);
            trace_push = 1'b1;
          end
          state_d = bus.step_mode ? STEP_WAIT : RUN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge pc_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      halt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  // The PC leaving on a step is the one just executed, so that is what the
  // trace records.
  pc_trace_buf #(
    .PC_W        (PC_W),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk      (pc_clk),
    .rst      (reset),
    .push     (trace_push),
    .clear    (trace_clear),
    .push_pc  (pc_q),
    .rd_idx   (bus.trace_idx),
    .rd_pc    (bus.trace_pc),
    .rd_valid (bus.trace_valid)
  );

  assign bus.pc_new      = pc_q;
  assign bus.running     = (state_q == RUN) || (state_q == STEP_WAIT);
  assign bus.done        = (state_q == HALTED);
  assign bus.timeout     = (state_q == TIMEOUT);
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// tb_mips_run_controller: two controllers (MAX_CYCLES 1000 and 20) share one
// stimulus stream; a behavioural run model predicts both every cycle, and
// directed literal expectations pin the model for each scenario.
module tb_mips_run_controller;

  localparam int PC_W  = 32;
  localparam int CNT_W = 16;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int MAX_A = 1000;
  localparam int MAX_B = 20;
  localparam int HIST  = 1024;

  logic             pc_clk = 1'b0;
  logic             reset  = 1'b1;
  logic             start = 1'b0, step_mode = 1'b0, step_req = 1'b0;
  logic [PC_W-1:0]  halt_pc = '0;
  logic [IDX_W-1:0] trace_idx = '0;
  bit               pc_loop = 1'b0;   // datapath: 0 = pc+1, 1 = 0->4->0

  int checks = 0;
  int errors = 0;

  always #5 pc_clk = ~pc_clk;

  function automatic logic [PC_W-1:0] dp_next(input bit loop, input logic [PC_W-1:0] pc);
    if (loop) return (pc == '0) ? 32'd4 : 32'd0;
    return pc + 32'd1;
  endfunction

  mips_run_controller_if #(.PC_W(PC_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus_a ();
  mips_run_controller_if #(.PC_W(PC_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus_b ();

  assign bus_a.start     = start;
  assign bus_a.step_mode = step_mode;
  assign bus_a.step_req  = step_req;
  assign bus_a.halt_pc   = halt_pc;
  assign bus_a.trace_idx = trace_idx;
  assign bus_a.pc_next   = dp_next(pc_loop, bus_a.pc_new);
  assign bus_b.start     = start;
  assign bus_b.step_mode = step_mode;
  assign bus_b.step_req  = step_req;
  assign bus_b.halt_pc   = halt_pc;
  assign bus_b.trace_idx = trace_idx;
  assign bus_b.pc_next   = dp_next(pc_loop, bus_b.pc_new);

  mips_run_controller #(
    .PC_W(PC_W), .RESET_PC(32'h0), .TRACE_DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_CYCLES(MAX_A)
  ) dut_a (.pc_clk(pc_clk), .reset(reset), .bus(bus_a.slave));

  mips_run_controller #(
    .PC_W(PC_W), .RESET_PC(32'h0), .TRACE_DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_CYCLES(MAX_B)
  ) dut_b (.pc_clk(pc_clk), .reset(reset), .bus(bus_b.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A run is "active" between start and its end; while active, a step either
  // happens every cycle or only on step_req (gated). The model keeps the full
  // history of executed PCs; the trace is simply its last DEPTH entries.
  int              m_max [2] = '{MAX_A, MAX_B};
  bit              m_active [2];
  bit              m_gated [2];
  bit              m_done [2];
  bit              m_to [2];
  logic [PC_W-1:0] m_pc [2];
  logic [PC_W-1:0] m_halt [2];
  int              m_cnt [2];
  int              m_n [2];
  logic [PC_W-1:0] m_hist [2][HIST];

  always @(posedge pc_clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_active[k] = 0; m_gated[k] = 0; m_done[k] = 0; m_to[k] = 0;
        m_pc[k] = '0; m_halt[k] = '0; m_cnt[k] = 0; m_n[k] = 0;
      end else if (!m_active[k]) begin
        if (start) begin
          m_pc[k] = '0; m_halt[k] = halt_pc; m_cnt[k] = 0; m_n[k] = 0;
          m_active[k] = 1; m_done[k] = 0; m_to[k] = 0; m_gated[k] = step_mode;
        end
      end else if (m_pc[k] == m_halt[k]) begin
        m_active[k] = 0; m_done[k] = 1;
      end else if (m_cnt[k] == m_max[k]) begin
        m_active[k] = 0; m_to[k] = 1;
      end else begin
        if (!m_gated[k] || step_req) begin
          if (m_n[k] < HIST) m_hist[k][m_n[k]] = m_pc[k];
          m_n[k]++;
          m_pc[k] = dp_next(pc_loop, m_pc[k]);
          m_cnt[k]++;
        end
        m_gated[k] = step_mode;
      end
    end
  end

  task automatic cmp_inst(input int k, input logic [PC_W-1:0] pc, input logic run,
                          input logic dn, input logic to, input logic [CNT_W-1:0] cnt,
                          input logic [PC_W-1:0] tpc, input logic tv);
    int fill;
    bit v;
    logic [PC_W-1:0] epc;
    string n;
    n    = (k == 0) ? "a" : "b";
    fill = (m_n[k] < DEPTH) ? m_n[k] : DEPTH;
    v    = (int'(trace_idx) < fill);
    epc  = v ? m_hist[k][m_n[k] - 1 - int'(trace_idx)] : '0;
    check({"model ", n, ".pc_new"},      pc,  m_pc[k]);
    check({"model ", n, ".running"},     run, m_active[k]);
    check({"model ", n, ".done"},        dn,  m_done[k]);
    check({"model ", n, ".timeout"},     to,  m_to[k]);
    check({"model ", n, ".cycle_count"}, cnt, CNT_W'(m_cnt[k]));
    check({"model ", n, ".trace_valid"}, tv,  v);
    check({"model ", n, ".trace_pc"},    tpc, epc);
  endtask

  always @(posedge pc_clk) begin
    #1;
    cmp_inst(0, bus_a.pc_new, bus_a.running, bus_a.done, bus_a.timeout,
             bus_a.cycle_count, bus_a.trace_pc, bus_a.trace_valid);
    cmp_inst(1, bus_b.pc_new, bus_b.running, bus_b.done, bus_b.timeout,
             bus_b.cycle_count, bus_b.trace_pc, bus_b.trace_valid);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge pc_clk);
    start = 0; step_req = 0; reset = 1;
    @(negedge pc_clk);
    reset = 0;
  endtask

  task automatic pulse_start();
    @(negedge pc_clk); start = 1;
    @(negedge pc_clk); start = 0;
  endtask

  task automatic pulse_step();
    @(negedge pc_clk); step_req = 1;
    @(negedge pc_clk); step_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge pc_clk);
    #1;
    check("reset pc_new",      bus_a.pc_new, 32'h0);
    check("reset running",     bus_a.running, 1'b0);
    check("reset done",        bus_a.done, 1'b0);
    check("reset timeout",     bus_a.timeout, 1'b0);
    check("reset cycle_count", bus_a.cycle_count, 16'd0);
    check("reset trace_valid", bus_a.trace_valid, 1'b0);
    reset = 0;

    // Free-run halt at 0x23; instance b times out first at 20 steps
    halt_pc = 32'h23; step_mode = 0; pc_loop = 0;
    pulse_start();
    repeat (40) @(negedge pc_clk);
    #1;
    check("halt a done",        bus_a.done, 1'b1);
    check("halt a running",     bus_a.running, 1'b0);
    check("halt a pc_new",      bus_a.pc_new, 32'h23);
    check("halt a cycle_count", bus_a.cycle_count, 16'd35);
    check("halt b timeout",     bus_b.timeout, 1'b1);
    check("halt b done",        bus_b.done, 1'b0);
    check("halt b pc_new",      bus_b.pc_new, 32'h14);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge pc_clk); trace_idx = IDX_W'(i); #1;
      check($sformatf("halt a trace[%0d]", i), bus_a.trace_pc, 32'h22 - i);
      check($sformatf("halt b trace[%0d]", i), bus_b.trace_pc, 32'h13 - i);
    end

    // Timeout with a 0->4->0 loop that never reaches 0x100
    do_reset();
    halt_pc = 32'h100; pc_loop = 1; trace_idx = '0;
    pulse_start();
    repeat (30) @(negedge pc_clk);
    #1;
    check("tmo b timeout",     bus_b.timeout, 1'b1);
    check("tmo b done",        bus_b.done, 1'b0);
    check("tmo b running",     bus_b.running, 1'b0);
    check("tmo b cycle_count", bus_b.cycle_count, 16'd20);
    check("tmo a running",     bus_a.running, 1'b1);
    check("tmo a cycle_count", bus_a.cycle_count, 16'd30);

    // Single-step: three spaced pulses, idle cycles and a stray start change nothing
    do_reset();
    pc_loop = 0; halt_pc = 32'h100; step_mode = 1;
    pulse_start();
    for (int p = 0; p < 3; p++) begin
      repeat (4) @(negedge pc_clk);
      pulse_step();
    end
    #1;
    check("step pc_new",      bus_a.pc_new, 32'd3);
    check("step cycle_count", bus_a.cycle_count, 16'd3);
    repeat (5) @(negedge pc_clk);
    pulse_start();
    #1;
    check("step idle pc_new",  bus_a.pc_new, 32'd3);
    check("step idle count",   bus_b.cycle_count, 16'd3);
    check("step idle running", bus_a.running, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge pc_clk); trace_idx = IDX_W'(i); #1;
      check($sformatf("part valid[%0d]", i), bus_a.trace_valid, (i < 3) ? 1'b1 : 1'b0);
      check($sformatf("part trace[%0d]", i), bus_a.trace_pc, (i < 3) ? 32'(2 - i) : 32'h0);
    end
    @(negedge pc_clk); step_req = 1;
    repeat (8) @(negedge pc_clk);
    step_req = 0; trace_idx = 3'd7;
    #1;
    check("wrap cycle_count", bus_a.cycle_count, 16'd11);
    check("wrap trace[7]",    bus_a.trace_pc, 32'd3);
    @(negedge pc_clk); trace_idx = 3'd0; #1;
    check("wrap trace[0]",    bus_a.trace_pc, 32'd10);

    // Asynchronous reset in the middle of a free run
    do_reset();
    step_mode = 0; trace_idx = '0;
    pulse_start();
    repeat (10) @(negedge pc_clk);
    #1;
    check("abort pre count", bus_a.cycle_count, 16'd10);
    #1; reset = 1; #1;
    check("abort pc_new",      bus_a.pc_new, 32'h0);
    check("abort running",     bus_a.running, 1'b0);
    check("abort cycle_count", bus_a.cycle_count, 16'd0);
    check("abort trace_valid", bus_a.trace_valid, 1'b0);
    @(negedge pc_clk); reset = 0;

    // Halt and timeout on the same cycle, stray step_req, then restart
    halt_pc = 32'h14;
    pulse_start();
    repeat (25) @(negedge pc_clk);
    #1;
    check("prio b done",        bus_b.done, 1'b1);
    check("prio b timeout",     bus_b.timeout, 1'b0);
    check("prio b cycle_count", bus_b.cycle_count, 16'd20);
    pulse_step();
    #1;
    check("prio stray step pc", bus_b.pc_new, 32'h14);
    pulse_start();
    #1;
    check("restart pc_new",      bus_b.pc_new, 32'h0);
    check("restart cycle_count", bus_b.cycle_count, 16'd0);
    check("restart running",     bus_b.running, 1'b1);
    check("restart done",        bus_b.done, 1'b0);
    repeat (3) @(negedge pc_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
